// File: rtl/alu_ctrl_seq.sv
// Registered ALU control decoder with valid/ready handshake.
// MUL/UDIV are sequenced through a latency counter before the result is offered.
module alu_ctrl_seq #(
  parameter int unsigned OPC_W   = 11,
  parameter int unsigned CTRL_W  = 4,
  parameter int unsigned MUL_LAT = 3,
  parameter int unsigned DIV_LAT = 8
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        alu_op,
  input  logic [OPC_W-1:0]  opcode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] alu_ctrl,
  output logic              alu_start,
  output logic              busy,
  output logic              illegal
);

  localparam logic [OPC_W-1:0] OP_ADD  = OPC_W'(11'b10001011000);
  localparam logic [OPC_W-1:0] OP_SUB  = OPC_W'(11'b11001011000);
  localparam logic [OPC_W-1:0] OP_AND  = OPC_W'(11'b10001010000);
  localparam logic [OPC_W-1:0] OP_ORR  = OPC_W'(11'b10101010000);
  localparam logic [OPC_W-1:0] OP_EOR  = OPC_W'(11'b11001010000);
  localparam logic [OPC_W-1:0] OP_LSL  = OPC_W'(11'b11010011011);
  localparam logic [OPC_W-1:0] OP_LSR  = OPC_W'(11'b11010011010);
  localparam logic [OPC_W-1:0] OP_MUL  = OPC_W'(11'b10011011000);
  localparam logic [OPC_W-1:0] OP_UDIV = OPC_W'(11'b10011010110);

  localparam logic [3:0] MUL_CNT = 4'(MUL_LAT - 1);
  localparam logic [3:0] DIV_CNT = 4'(DIV_LAT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    OUT  = 2'd2
  } state_t;

  state_t              state, stateNext;
  logic [3:0]          cnt;
  logic [CTRL_W-1:0]   ctrlReg;
  logic                illegalReg;
  logic                startReg;

  logic [CTRL_W-1:0]   decCtrl;
  logic                decIll;
  logic                decMulti;
  logic [3:0]          decCnt;
  logic                accept;

  always_comb begin
    decCtrl  = '0;
    decIll   = 1'b0;
    decMulti = 1'b0;
    decCnt   = '0;
    case (alu_op)
      2'd0: decCtrl = CTRL_W'(2);
      2'd1: decCtrl = CTRL_W'(7);
      2'd3: decCtrl = CTRL_W'(8);
      default: begin
        case (opcode)
          OP_ADD:  decCtrl = CTRL_W'(2);
          OP_SUB:  decCtrl = CTRL_W'(6);
          OP_AND:  decCtrl = CTRL_W'(0);
          OP_ORR:  decCtrl = CTRL_W'(1);
          OP_EOR:  decCtrl = CTRL_W'(3);
          OP_LSL:  decCtrl = CTRL_W'(4);
          OP_LSR:  decCtrl = CTRL_W'(5);
          OP_MUL: begin
            decCtrl  = CTRL_W'(9);
            decMulti = 1'b1;
            decCnt   = MUL_CNT;
          end
          OP_UDIV: begin
            decCtrl  = CTRL_W'(10);
            decMulti = 1'b1;
            decCnt   = DIV_CNT;
          end
          default: begin
            decCtrl = '1;
            decIll  = 1'b1;
          end
        endcase
      end
    endcase
  end

  // flush blocks acceptance so an op offered alongside it is simply dropped
  always_comb begin
    in_ready  = 1'b0;
    stateNext = state;
    case (state)
      IDLE: in_ready = ~flush;
      OUT:  in_ready = ~flush & out_ready;
      default: in_ready = 1'b0;
    endcase
    accept = in_valid & in_ready;
    case (state)
      IDLE: begin
        if (accept) stateNext = decMulti ? EXEC : OUT;
      end
      EXEC: begin
        if (cnt == 4'd0) stateNext = OUT;
      end
      OUT: begin
        if (out_ready) begin
          if (accept) stateNext = decMulti ? EXEC : OUT;
          else        stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state      <= IDLE;
      cnt        <= '0;
      ctrlReg    <= '0;
      illegalReg <= 1'b0;
      startReg   <= 1'b0;
    end else if (flush) begin
      state    <= IDLE;
      cnt      <= '0;
      startReg <= 1'b0;
    end else begin
      state    <= stateNext;
      startReg <= accept & decMulti;
      if (accept) begin
        ctrlReg    <= decCtrl;
        illegalReg <= decIll;
        cnt        <= decCnt;
      end else if (state == EXEC && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
    end
  end

  assign out_valid = (state == OUT);
  assign busy      = (state == EXEC);
  assign alu_start = startReg;
  assign alu_ctrl  = ctrlReg;
  assign illegal   = illegalReg;

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Directed-vector bench for alu_ctrl_seq: decode, multi-cycle timing,
// back-pressure, flush and asynchronous reset.
module tb_alu_ctrl_seq;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  alu_op;
  logic [10:0] opcode;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  alu_ctrl;
  logic        alu_start;
  logic        busy;
  logic        illegal;

  int unsigned nVec  = 0;
  int unsigned nMiss = 0;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_MUL  = 11'b10011011000;
  localparam logic [10:0] OP_UDIV = 11'b10011010110;
  localparam logic [10:0] OP_BAD  = 11'b11111111111;

  alu_ctrl_seq #(
    .OPC_W  (11),
    .CTRL_W (4),
    .MUL_LAT(3),
    .DIV_LAT(8)
  ) dut (
    .CLK      (CLK),
    .RESET_N  (RESET_N),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .alu_op   (alu_op),
    .opcode   (opcode),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .alu_ctrl (alu_ctrl),
    .alu_start(alu_start),
    .busy     (busy),
    .illegal  (illegal)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nVec++;
    if (got !== exp) begin
      nMiss++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [10:0] opc);
    in_valid = v;
    alu_op   = op;
    opcode   = opc;
  endtask

  initial begin
    RESET_N   = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, 2'd0, '0);
    #3;
    check("rst_out_valid", {31'b0, out_valid}, 0);
    check("rst_alu_ctrl",  {28'b0, alu_ctrl}, 0);
    check("rst_busy",      {31'b0, busy}, 0);
    check("rst_alu_start", {31'b0, alu_start}, 0);
    check("rst_illegal",   {31'b0, illegal}, 0);
    tick(); tick();
    RESET_N = 1'b1;

    // single SUB
    drive(1'b1, 2'd2, OP_SUB);
    #1 check("sub_in_ready", {31'b0, in_ready}, 1);
    tick();
    drive(1'b0, 2'd0, '0);
    check("sub_out_valid", {31'b0, out_valid}, 1);
    check("sub_alu_ctrl",  {28'b0, alu_ctrl}, 6);
    check("sub_illegal",   {31'b0, illegal}, 0);
    tick();
    check("sub_drain", {31'b0, out_valid}, 0);

    // back-to-back single-cycle ops
    drive(1'b1, 2'd2, OP_ADD);
    tick();
    check("b2b_add_ctrl", {28'b0, alu_ctrl}, 2);
    check("b2b_add_ov",   {31'b0, out_valid}, 1);
    drive(1'b1, 2'd2, OP_AND);
    #1 check("b2b_rdy1", {31'b0, in_ready}, 1);
    tick();
    check("b2b_and_ctrl", {28'b0, alu_ctrl}, 0);
    check("b2b_and_ov",   {31'b0, out_valid}, 1);
    drive(1'b1, 2'd2, OP_ORR);
    #1 check("b2b_rdy2", {31'b0, in_ready}, 1);
    tick();
    check("b2b_orr_ctrl", {28'b0, alu_ctrl}, 1);
    check("b2b_orr_ov",   {31'b0, out_valid}, 1);
    drive(1'b0, 2'd0, '0);
    tick();
    check("b2b_drain", {31'b0, out_valid}, 0);

    // MUL, latency 3
    drive(1'b1, 2'd2, OP_MUL);
    tick();
    drive(1'b0, 2'd0, '0);
    check("mul_c1_start", {31'b0, alu_start}, 1);
    check("mul_c1_busy",  {31'b0, busy}, 1);
    check("mul_c1_rdy",   {31'b0, in_ready}, 0);
    check("mul_c1_ov",    {31'b0, out_valid}, 0);
    tick();
    check("mul_c2_start", {31'b0, alu_start}, 0);
    check("mul_c2_busy",  {31'b0, busy}, 1);
    tick();
    check("mul_c3_busy",  {31'b0, busy}, 1);
    check("mul_c3_ov",    {31'b0, out_valid}, 0);
    tick();
    check("mul_c4_ov",    {31'b0, out_valid}, 1);
    check("mul_c4_ctrl",  {28'b0, alu_ctrl}, 9);
    check("mul_c4_busy",  {31'b0, busy}, 0);
    tick();
    check("mul_drain", {31'b0, out_valid}, 0);

    // back-pressure: pass-b held while a CBNZ waits at the input
    out_ready = 1'b0;
    drive(1'b1, 2'd1, '0);
    tick();
    drive(1'b1, 2'd3, OP_BAD);
    for (int i = 0; i < 5; i++) begin
      check("bp_ov",   {31'b0, out_valid}, 1);
      check("bp_ctrl", {28'b0, alu_ctrl}, 7);
      check("bp_rdy",  {31'b0, in_ready}, 0);
      if (i < 4) tick();
    end
    out_ready = 1'b1;
    #1 check("bp_release_rdy", {31'b0, in_ready}, 1);
    tick();
    check("bp_next_ov",   {31'b0, out_valid}, 1);
    check("bp_next_ctrl", {28'b0, alu_ctrl}, 8);
    drive(1'b0, 2'd0, '0);
    tick();
    check("bp_drain", {31'b0, out_valid}, 0);

    // illegal R-type, then a legal op clears the flag
    drive(1'b1, 2'd2, OP_BAD);
    tick();
    check("ill_ctrl", {28'b0, alu_ctrl}, 15);
    check("ill_flag", {31'b0, illegal}, 1);
    check("ill_ov",   {31'b0, out_valid}, 1);
    drive(1'b1, 2'd0, OP_BAD);
    tick();
    check("ldur_ctrl", {28'b0, alu_ctrl}, 2);
    check("ldur_ill",  {31'b0, illegal}, 0);
    drive(1'b0, 2'd0, '0);
    tick();

    // UDIV aborted by flush in EXEC cycle 3
    drive(1'b1, 2'd2, OP_UDIV);
    tick();
    drive(1'b0, 2'd0, '0);
    check("div_c1_start", {31'b0, alu_start}, 1);
    tick(); tick();
    check("div_c3_busy", {31'b0, busy}, 1);
    flush = 1'b1;
    drive(1'b1, 2'd0, '0);
    #1 check("flush_rdy", {31'b0, in_ready}, 0);
    tick();
    flush = 1'b0;
    drive(1'b0, 2'd0, '0);
    check("flush_busy",  {31'b0, busy}, 0);
    check("flush_ov",    {31'b0, out_valid}, 0);
    check("flush_start", {31'b0, alu_start}, 0);
    check("flush_ctrl",  {28'b0, alu_ctrl}, 10);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("flush_no_ov", {31'b0, out_valid}, 0);
    end

    // UDIV aborted by asynchronous reset in EXEC cycle 3
    drive(1'b1, 2'd2, OP_UDIV);
    tick();
    drive(1'b0, 2'd0, '0);
    tick(); tick();
    check("rdiv_c3_busy", {31'b0, busy}, 1);
    #2 RESET_N = 1'b0;
    #1;
    check("arst_busy",  {31'b0, busy}, 0);
    check("arst_ctrl",  {28'b0, alu_ctrl}, 0);
    check("arst_ov",    {31'b0, out_valid}, 0);
    check("arst_start", {31'b0, alu_start}, 0);
    tick(); tick();
    RESET_N = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("arst_no_ov", {31'b0, out_valid}, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
    $finish;
  end

endmodule
